// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: buffers commands in a FIFO, issues one at a time,
// waits out the ALU latency and returns each captured result with its tag.
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 2,
    parameter int ALU_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [7:0]       i_cmd_a,
    input  logic [7:0]       i_cmd_b,
    input  logic [3:0]       i_cmd_sel,
    input  logic [TAG_W-1:0] i_cmd_tag,
    output logic             o_cmd_err,
    output logic [7:0]       o_alu_a,
    output logic [7:0]       o_alu_b,
    output logic [3:0]       o_alu_sel,
    input  logic [7:0]       i_alu_out,
    input  logic             i_alu_zero,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [7:0]       o_res_data,
    output logic             o_res_zero,
    output logic [TAG_W-1:0] o_res_tag,
    output logic             o_busy
);

    localparam int         PTR_W    = $clog2(DEPTH);
    localparam int         CNT_W    = PTR_W + 1;
    localparam int         WCNT_W   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [3:0] SEL_HOLD = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [3:0]       sel;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    state_t            r_state;
    state_t            w_state_next;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_cmd_err;
    logic [7:0]        r_alu_a;
    logic [7:0]        r_alu_b;
    logic [3:0]        r_alu_sel;
    logic [TAG_W-1:0]  r_tag;
    logic              r_res_valid;
    logic [7:0]        r_res_data;
    logic              r_res_zero;
    logic [TAG_W-1:0]  r_res_tag;

    logic   w_legal;
    logic   w_cmd_hs;
    logic   w_push;
    logic   w_pop;
    logic   w_capture;
    logic   w_res_accept;
    entry_t w_head;
    entry_t w_wr_entry;

    assign o_cmd_ready = (r_count != CNT_W'(DEPTH));
    assign w_legal     = (i_cmd_sel == 4'b0000) || (i_cmd_sel == 4'b0001) ||
                         (i_cmd_sel == 4'b0010) || (i_cmd_sel == 4'b0110);
    assign w_cmd_hs    = i_cmd_valid && o_cmd_ready;
    assign w_push      = w_cmd_hs && w_legal;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_wr_entry  = {i_cmd_a, i_cmd_b, i_cmd_sel, i_cmd_tag};

    // Storage is never reset: only entries between the pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_cmd_hs && !w_legal;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_res_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_res_ready) begin
                    w_res_accept = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The ALU samples the operands on the ISSUE edge; the counter covers its latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= SEL_HOLD;
            r_tag       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_zero  <= 1'b0;
            r_res_tag   <= '0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= WCNT_W'(ALU_LAT - 1);
            end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - WCNT_W'(1);
            end
            if (w_pop) begin
                r_alu_a   <= w_head.a;
                r_alu_b   <= w_head.b;
                r_alu_sel <= w_head.sel;
                r_tag     <= w_head.tag;
            end else if (w_capture) begin
                r_alu_sel <= SEL_HOLD;
            end
            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_data  <= i_alu_out;
                r_res_zero  <= i_alu_zero;
                r_res_tag   <= r_tag;
            end else if (w_res_accept) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign o_cmd_err   = r_cmd_err;
    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_sel   = r_alu_sel;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_zero  = r_res_zero;
    assign o_res_tag   = r_res_tag;
    assign o_busy      = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: driver queues expected results, a monitor
// checks every presented result; a small registered ALU stands in for the real one.
module tb_alu_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 2;
    localparam int ALU_LAT = 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic [7:0]       data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [7:0]       cmd_a = '0;
    logic [7:0]       cmd_b = '0;
    logic [3:0]       cmd_sel = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic             res_ready = 1'b0;
    logic             o_cmd_ready, o_cmd_err, o_res_valid, o_res_zero, o_busy;
    logic [7:0]       o_alu_a, o_alu_b, o_res_data;
    logic [3:0]       o_alu_sel;
    logic [TAG_W-1:0] o_res_tag;
    logic [7:0]       alu_out;
    logic             alu_zero;
    logic [8:0]       alu_pipe [ALU_LAT];

    int   n_checks = 0;
    int   n_fail = 0;
    int   rr_mode = 0;  // 0: hold low, 1: hold high, 2: random, 3: one-cycle pulse
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ALU_LAT(ALU_LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_sel(cmd_sel), .i_cmd_tag(cmd_tag),
        .o_cmd_err(o_cmd_err),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_sel(o_alu_sel),
        .i_alu_out(alu_out), .i_alu_zero(alu_zero),
        .o_res_valid(o_res_valid), .i_res_ready(res_ready),
        .o_res_data(o_res_data), .o_res_zero(o_res_zero), .o_res_tag(o_res_tag),
        .o_busy(o_busy)
    );

    // Stand-in ALU: registered, holds its output while Sel is the hold code.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s);
        logic [7:0] y;
        case (s)
            4'h0:    y = a & b;
            4'h1:    y = a | b;
            4'h2:    y = a + b;
            4'h6:    y = a - b;
            default: y = 8'h00;
        endcase
        return {(y == 8'h00), y};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ALU_LAT; i++) alu_pipe[i] <= '0;
        end else begin
            if (o_alu_sel != 4'hF) alu_pipe[0] <= alu_fn(o_alu_a, o_alu_b, o_alu_sel);
            for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
        end
    end
    assign {alu_zero, alu_out} = alu_pipe[ALU_LAT-1];

    // Reference result from the opcode rules, in plain integer arithmetic.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] sel, input logic [TAG_W-1:0] tag);
        int   r;
        exp_t e;
        case (sel)
            4'h0:    r = int'(a) & int'(b);
            4'h1:    r = int'(a) | int'(b);
            4'h2:    r = (int'(a) + int'(b)) % 256;
            4'h6:    r = (int'(a) - int'(b) + 256) % 256;
            default: r = 0;
        endcase
        e.data = r[7:0];
        e.zero = (r == 0);
        e.tag  = tag;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            2:       res_ready = 1'($urandom_range(0, 1));
            default: begin res_ready = 1'b1; rr_mode = 0; end
        endcase
    end

    // Monitor: compares every presented result against the scoreboard head.
    initial begin : monitor
        logic             prev_valid;
        logic             prev_stall;
        logic [3:0]       prev_sel;
        logic [7:0]       held_data;
        logic             held_zero;
        logic [TAG_W-1:0] held_tag;
        int               since_issue;
        prev_valid = 1'b0; prev_stall = 1'b0; prev_sel = 4'hF; since_issue = 0;
        held_data = '0; held_zero = 1'b0; held_tag = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0; prev_stall = 1'b0; prev_sel = 4'hF;
                continue;
            end
            if (prev_sel == 4'hF && o_alu_sel != 4'hF) since_issue = 0;
            else since_issue++;
            // Pop edge loads Alu_Sel; capture lands ALU_LAT+1 edges later.
            if (o_res_valid && !prev_valid) check("res_latency", since_issue, ALU_LAT + 1);
            if (o_res_valid) begin
                check("hold_sel", o_alu_sel, 4'hF);
                if (prev_stall) begin
                    check("hold_data_stable", o_res_data, held_data);
                    check("hold_zero_stable", o_res_zero, held_zero);
                    check("hold_tag_stable", o_res_tag, held_tag);
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_result_valid", o_res_valid, 1'b0);
                end else begin
                    check("res_data", o_res_data, exp_q[0].data);
                    check("res_zero", o_res_zero, exp_q[0].zero);
                    check("res_tag", o_res_tag, exp_q[0].tag);
                    if (res_ready) begin
                        $display("RES  tag=%0d data=%02h zero=%0d", o_res_tag, o_res_data, o_res_zero);
                        void'(exp_q.pop_front());
                    end
                end
                prev_stall = !res_ready;
                held_data = o_res_data; held_zero = o_res_zero; held_tag = o_res_tag;
            end else begin
                prev_stall = 1'b0;
            end
            prev_valid = o_res_valid;
            prev_sel   = o_alu_sel;
        end
    end

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                        input logic [TAG_W-1:0] tag);
        int   guard;
        logic legal;
        legal = (sel == 4'h0) || (sel == 4'h1) || (sel == 4'h2) || (sel == 4'h6);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_tag = tag;
        guard = 0;
        while (!o_cmd_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!o_cmd_ready) begin
            check("cmd_accept_timeout", 1'b0, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        if (legal) exp_q.push_back(model(a, b, sel, tag));
        $display("CMD  a=%02h b=%02h sel=%h tag=%0d legal=%0d", a, b, sel, tag, legal);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_err", o_cmd_err, !legal);
        if (!legal) begin
            @(negedge clk);
            check("cmd_err_one_cycle", o_cmd_err, 1'b0);
        end
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || o_busy) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_drained"}, (exp_q.size() == 0) && !o_busy, 1'b1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [3:0] legal_ops [4];
        logic [3:0] sel;
        int         guard;
        legal_ops[0] = 4'h0; legal_ops[1] = 4'h1; legal_ops[2] = 4'h2; legal_ops[3] = 4'h6;

        // Reset values, asserted asynchronously before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_cmd_ready", o_cmd_ready, 1'b1);
        check("rst_cmd_err", o_cmd_err, 1'b0);
        check("rst_alu_a", o_alu_a, 8'h00);
        check("rst_alu_b", o_alu_b, 8'h00);
        check("rst_alu_sel", o_alu_sel, 4'hF);
        check("rst_res_valid", o_res_valid, 1'b0);
        check("rst_res_data", o_res_data, 8'h00);
        check("rst_res_zero", o_res_zero, 1'b0);
        check("rst_res_tag", o_res_tag, '0);
        check("rst_busy", o_busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_cmd_ready", o_cmd_ready, 1'b1);
            check("idle_res_valid", o_res_valid, 1'b0);
            check("idle_alu_sel", o_alu_sel, 4'hF);
            check("idle_busy", o_busy, 1'b0);
        end

        // Directed operations with the consumer always ready.
        rr_mode = 1;
        @(negedge clk);
        send(8'h80, 8'h80, 4'h2, 2'd1);
        wait_drain("add_zero");
        send(8'h05, 8'h07, 4'h6, 2'd2);
        send(8'hF0, 8'h0F, 4'h0, 2'd3);
        send(8'hF0, 8'h0F, 4'h1, 2'd0);
        wait_drain("sub_and_or");

        // Illegal opcode while one result is held and one entry is queued.
        rr_mode = 0;
        @(negedge clk);
        send(8'h11, 8'h22, 4'h2, 2'd1);
        send(8'h33, 8'h44, 4'h0, 2'd2);
        send(8'h55, 8'h66, 4'h3, 2'd3);
        check("illegal_ready", o_cmd_ready, 1'b1);
        rr_mode = 1;
        wait_drain("illegal");

        // Backpressure: five commands fill the FIFO behind one held result.
        rr_mode = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) send(8'(8'h10 * i + 3), 8'(i + 1), legal_ops[i % 4], 2'(i));
        check("full_not_ready", o_cmd_ready, 1'b0);
        repeat (8) @(negedge clk);
        check("full_still_not_ready", o_cmd_ready, 1'b0);
        check("full_result_held", o_res_valid, 1'b1);
        rr_mode = 1;
        wait_drain("backpressure");
        check("drain_ready", o_cmd_ready, 1'b1);

        // Randomized commands, including illegal opcodes and random backpressure.
        rr_mode = 2;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 8) sel = legal_ops[$urandom_range(0, 3)];
            else begin
                sel = 4'($urandom_range(3, 15));
                if (sel == 4'h6) sel = 4'h7;
            end
            case ($urandom_range(0, 5))
                0:       send(8'hFF, 8'h01, sel, 2'($urandom));
                1:       send(8'h00, 8'h00, sel, 2'($urandom));
                default: send(8'($urandom), 8'($urandom), sel, 2'($urandom));
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rr_mode = 1;
        wait_drain("random");

        // Reset while the issued command waits, with three entries queued.
        rr_mode = 0;
        @(negedge clk);
        send(8'h01, 8'h02, 4'h2, 2'd0);
        send(8'h03, 8'h04, 4'h2, 2'd1);
        send(8'h05, 8'h06, 4'h2, 2'd2);
        send(8'h07, 8'h08, 4'h2, 2'd3);
        send(8'h09, 8'h0A, 4'h2, 2'd0);
        rr_mode = 3;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (o_alu_sel == 4'hF && guard < 50);
        check("midrst_issue_seen", o_alu_sel != 4'hF, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_res_valid", o_res_valid, 1'b0);
        check("midrst_alu_sel", o_alu_sel, 4'hF);
        check("midrst_alu_a", o_alu_a, 8'h00);
        check("midrst_cmd_ready", o_cmd_ready, 1'b1);
        check("midrst_busy", o_busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("postrst_res_valid", o_res_valid, 1'b0);
            check("postrst_busy", o_busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
